// File: rtl/div_share_ctrl_pkg.sv
// Shared types for the divider-sharing controller: FSM states, owner ids, width.
package div_share_ctrl_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_L1 = 1'b0,
    OWN_L2 = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_L1) ? OWN_L2 : OWN_L1;
  endfunction
endpackage

// File: rtl/div_share_ctrl_grant.sv
// Combinational grant pick between the two EX lines.
module div_grant_pick
  import div_share_ctrl_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic   req1_i,
  input  logic   req2_i,
  input  owner_e last_owner_i,
  output owner_e gnt_owner_o,
  output logic   gnt_vld_o
);

  // A lone requester always wins; a tie alternates or favours line1.
  always_comb begin
    gnt_vld_o   = req1_i | req2_i;
    gnt_owner_o = OWN_L1;
    if (req1_i && req2_i)
      gnt_owner_o = RR_EN ? other_owner(last_owner_i) : OWN_L1;
    else if (req2_i)
      gnt_owner_o = OWN_L2;
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Arbitrates two EX lines onto one shared iterative divider and returns the result.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              excep_flush_i,
  input  logic              line1_div_req_i,
  input  logic              line1_div_sign_i,
  input  logic [DATA_W-1:0] line1_dividend_i,
  input  logic [DATA_W-1:0] line1_divisor_i,
  input  logic              line2_div_req_i,
  input  logic              line2_div_sign_i,
  input  logic [DATA_W-1:0] line2_dividend_i,
  input  logic [DATA_W-1:0] line2_divisor_i,
  output logic              line1_div_done_o,
  output logic              line2_div_done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              busy_o,
  output logic              div_en_o,
  output logic              div_signed_o,
  output logic [DATA_W-1:0] dividend_o,
  output logic [DATA_W-1:0] divisor_o,
  output logic              div_clr_o,
  input  logic              div_finished_i,
  input  logic [DATA_W-1:0] div_quotient_i,
  input  logic [DATA_W-1:0] div_remainder_i
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [DATA_W-1:0] quot_q, quot_d, rem_q, rem_d;

  owner_e gnt_owner;
  logic   gnt_vld;
  logic   owner_req;
  logic   cancel;
  logic   done_ok;

  div_grant_pick #(.RR_EN(RR_EN)) u_pick (
    .req1_i      (line1_div_req_i),
    .req2_i      (line2_div_req_i),
    .last_owner_i(last_owner_q),
    .gnt_owner_o (gnt_owner),
    .gnt_vld_o   (gnt_vld)
  );

  // Cancel means the current owner let go of its request mid-operation.
  assign owner_req = (owner_q == OWN_L1) ? line1_div_req_i : line2_div_req_i;
  assign cancel    = (state_q == ST_RUN) && !owner_req;

  // Next-state: grant/latch in IDLE, capture result in RUN; flush beats everything.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    sign_d       = sign_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!excep_flush_i && gnt_vld) begin
          state_d      = ST_RUN;
          owner_d      = gnt_owner;
          last_owner_d = gnt_owner;
          if (gnt_owner == OWN_L1) begin
            sign_d = line1_div_sign_i;
            dvd_d  = line1_dividend_i;
            dvs_d  = line1_divisor_i;
          end else begin
            sign_d = line2_div_sign_i;
            dvd_d  = line2_dividend_i;
            dvs_d  = line2_divisor_i;
          end
        end
      end
      ST_RUN: begin
        if (excep_flush_i || cancel) begin
          state_d = ST_IDLE;
        end else if (div_finished_i) begin
          state_d = ST_DONE;
          quot_d  = div_quotient_i;
          rem_d   = div_remainder_i;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; last_owner resets to line2 so line1 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_L1;
      last_owner_q <= OWN_L2;
      sign_q       <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      sign_q       <= sign_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
    end
  end

  // The divider only ever sees the latched owner operands.
  assign busy_o       = (state_q != ST_IDLE);
  assign div_en_o     = (state_q == ST_RUN);
  assign div_signed_o = sign_q;
  assign dividend_o   = dvd_q;
  assign divisor_o    = dvs_q;
  assign div_clr_o    = excep_flush_i | cancel;
  assign quotient_o   = quot_q;
  assign remainder_o  = rem_q;

  // A flush landing on the DONE cycle suppresses the pulse as well.
  assign done_ok          = (state_q == ST_DONE) && !excep_flush_i;
  assign line1_div_done_o = done_ok && (owner_q == OWN_L1);
  assign line2_div_done_o = done_ok && (owner_q == OWN_L2);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a behavioural shared-divider model.
module tb_div_share_ctrl;

  typedef struct {
    int          line;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_drv = 1'b0, fin_flush = 1'b0, excep_flush_i;
  logic req1 = 1'b0, sgn1 = 1'b0, req2 = 1'b0, sgn2 = 1'b0;
  logic [31:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
  logic div_finished_i = 1'b0;
  logic [31:0] div_q = '0, div_r = '0;

  logic d1, d2, busy_o, div_en_o, div_signed_o, div_clr_o;
  logic [31:0] quotient_o, remainder_o, dividend_o, divisor_o;
  logic f_d1, f_d2, f_busy, f_en, f_sgn, f_clr;
  logic [31:0] f_q, f_r, f_dvd, f_dvs;

  int n_tests = 0, n_fail = 0;
  exp_t exp_q[$];
  int lat = 3, cnt = 0;
  bit flush_at_fin = 1'b0;
  int fix_c1 = 0, fix_c2 = 0;
  logic [31:0] mq, mr;

  assign excep_flush_i = flush_drv | fin_flush;

  always #5 clk = ~clk;

  div_share_ctrl #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .excep_flush_i(excep_flush_i),
    .line1_div_req_i(req1), .line1_div_sign_i(sgn1), .line1_dividend_i(a1), .line1_divisor_i(b1),
    .line2_div_req_i(req2), .line2_div_sign_i(sgn2), .line2_dividend_i(a2), .line2_divisor_i(b2),
    .line1_div_done_o(d1), .line2_div_done_o(d2), .quotient_o(quotient_o), .remainder_o(remainder_o),
    .busy_o(busy_o), .div_en_o(div_en_o), .div_signed_o(div_signed_o), .dividend_o(dividend_o),
    .divisor_o(divisor_o), .div_clr_o(div_clr_o), .div_finished_i(div_finished_i),
    .div_quotient_i(div_q), .div_remainder_i(div_r)
  );

  // Fixed-priority instance runs in lockstep on the same inputs.
  div_share_ctrl #(.RR_EN(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .excep_flush_i(excep_flush_i),
    .line1_div_req_i(req1), .line1_div_sign_i(sgn1), .line1_dividend_i(a1), .line1_divisor_i(b1),
    .line2_div_req_i(req2), .line2_div_sign_i(sgn2), .line2_dividend_i(a2), .line2_divisor_i(b2),
    .line1_div_done_o(f_d1), .line2_div_done_o(f_d2), .quotient_o(f_q), .remainder_o(f_r),
    .busy_o(f_busy), .div_en_o(f_en), .div_signed_o(f_sgn), .dividend_o(f_dvd),
    .divisor_o(f_dvs), .div_clr_o(f_clr), .div_finished_i(div_finished_i),
    .div_quotient_i(div_q), .div_remainder_i(div_r)
  );

  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Shared divider model: finishes 'lat' cycles into an enabled run.
  always @(posedge clk) begin
    #1;
    div_finished_i = 1'b0;
    fin_flush      = 1'b0;
    if (div_en_o) begin
      cnt++;
      if (cnt == lat) begin
        ref_div(div_signed_o, dividend_o, divisor_o, mq, mr);
        div_q          = mq;
        div_r          = mr;
        div_finished_i = 1'b1;
        fin_flush      = flush_at_fin;
        cnt            = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  // Monitor: every done pulse pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (d1 || d2)) begin
      check("done_onehot", 32'(d1 & d2), 32'd0);
      check("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_line", d1 ? 32'd1 : 32'd2, 32'(e.line));
        check("quotient", quotient_o, e.q);
        check("remainder", remainder_o, e.r);
      end
    end
  end

  // Counts done pulses of the fixed-priority instance.
  always @(negedge clk) begin
    if (f_d1) fix_c1++;
    if (f_d2) fix_c2++;
  end

  task automatic push_exp(input int line, input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.line = line;
    ref_div(s, a, b, e.q, e.r);
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int line, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (line == 1) begin req1 = 1'b1; sgn1 = s; a1 = a; b1 = b; end
    else           begin req2 = 1'b1; sgn2 = s; a2 = a; b2 = b; end
  endtask

  task automatic drop(input int line);
    if (line == 1) req1 = 1'b0; else req2 = 1'b0;
  endtask

  task automatic wait_done(input int line, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (line == 1) ? d1 : d2;
    end
    check($sformatf("line%0d_done_seen", line), 32'(seen), 32'd1);
  endtask

  // Issue one request, wait for its pulse, release in the IDLE cycle after DONE.
  task automatic run_one(input int line, input logic s, input logic [31:0] a, input logic [31:0] b);
    push_exp(line, s, a, b);
    set_req(line, s, a, b);
    wait_done(line, 100);
    @(posedge clk); #1;
    drop(line);
  endtask

  task automatic rand_ops(input logic s, output logic [31:0] a, output logic [31:0] b);
    a = $urandom;
    b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
    if (b == 32'd0) b = 32'd1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rc, rd, old_q;
    logic rs, rs2;
    int  first, second, model_last, c1, c2;
    bit  seen;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_en", 32'(div_en_o), 32'd0);
    check("rst_done", 32'({d1, d2}), 32'd0);
    check("rst_quot", quotient_o, 32'd0);
    check("rst_rem", remainder_o, 32'd0);
    check("rst_dividend", dividend_o, 32'd0);
    check("rst_clr", 32'(div_clr_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // line1 signed 100/7, 33-cycle divide, latency checks
    lat = 33;
    push_exp(1, 1'b1, 32'd100, 32'd7);
    set_req(1, 1'b1, 32'd100, 32'd7);
    @(posedge clk); @(negedge clk);
    check("run_busy", 32'(busy_o), 32'd1);
    check("run_en", 32'(div_en_o), 32'd1);
    check("run_dividend", dividend_o, 32'd100);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = div_finished_i;
    end
    check("fin_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("done_latency", 32'({d1, d2}), 32'b10);
    @(posedge clk); #1;
    drop(1);
    check("q_100_7", quotient_o, 32'd14);
    check("r_100_7", remainder_o, 32'd2);

    // line2 signed -7/2
    lat = 5;
    run_one(2, 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("q_m7_2", quotient_o, 32'hFFFF_FFFD);
    check("r_m7_2", remainder_o, 32'hFFFF_FFFF);

    // Tie: RR instance alternates, fixed instance keeps serving line1
    lat = 4;
    c1 = fix_c1; c2 = fix_c2;
    push_exp(1, 1'b0, 32'd1000, 32'd9);
    push_exp(2, 1'b0, 32'd77, 32'd5);
    set_req(1, 1'b0, 32'd1000, 32'd9);
    set_req(2, 1'b0, 32'd77, 32'd5);
    wait_done(1, 50);
    @(negedge clk);
    check("tie_idle_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("tie_l2_dividend", dividend_o, 32'd77);
    check("fix_l1_dividend", f_dvd, 32'd1000);
    wait_done(2, 50);
    @(posedge clk); #1;
    drop(1); drop(2);
    @(negedge clk);
    check("fix_l1_pulses", 32'(fix_c1 - c1), 32'd2);
    check("fix_l2_pulses", 32'(fix_c2 - c2), 32'd0);

    // Cancel at RUN cycle 5 with line2 pending
    lat = 50;
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'd500, 32'd4);
    repeat (2) @(posedge clk); #1;
    push_exp(2, 1'b0, 32'd9, 32'd3);
    set_req(2, 1'b0, 32'd9, 32'd3);
    repeat (3) @(posedge clk); #1;
    drop(1);
    @(negedge clk);
    check("cancel_clr", 32'(div_clr_o), 32'd1);
    @(negedge clk);
    lat = 4;
    check("cancel_idle", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("cancel_l2_dividend", dividend_o, 32'd9);
    wait_done(2, 50);
    @(posedge clk); #1;
    drop(2);
    check("q_9_3", quotient_o, 32'd3);
    check("r_9_3", remainder_o, 32'd0);

    // Flush on the finishing cycle
    lat = 6;
    flush_at_fin = 1'b1;
    old_q = quotient_o;
    set_req(1, 1'b0, 32'd1234, 32'd10);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = div_finished_i;
    end
    check("flush_fin_seen", 32'(seen), 32'd1);
    check("flush_clr", 32'(div_clr_o), 32'd1);
    @(posedge clk); #1;
    drop(1);
    flush_at_fin = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(busy_o), 32'd0);
    check("flush_no_done", 32'({d1, d2}), 32'd0);
    check("flush_quot_hold", quotient_o, old_q);

    // Reset mid-RUN, then first tie goes to line1
    lat = 40;
    set_req(1, 1'b1, 32'd55, 32'd5);
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy_o), 32'd0);
    check("mrst_en", 32'(div_en_o), 32'd0);
    check("mrst_quot", quotient_o, 32'd0);
    check("mrst_dividend", dividend_o, 32'd0);
    check("mrst_done", 32'({d1, d2}), 32'd0);
    drop(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat = 3;
    push_exp(1, 1'b0, 32'd40, 32'd6);
    push_exp(2, 1'b0, 32'd41, 32'd7);
    set_req(1, 1'b0, 32'd40, 32'd6);
    set_req(2, 1'b0, 32'd41, 32'd7);
    wait_done(1, 50);
    @(posedge clk); #1;
    drop(1);
    wait_done(2, 50);
    @(posedge clk); #1;
    drop(2);
    model_last = 2;

    // Randomised traffic: singles and ties
    for (int it = 0; it < 24; it++) begin
      lat = $urandom_range(1, 8);
      rs  = 1'($urandom_range(0, 1));
      rand_ops(rs, ra, rb);
      if ($urandom_range(0, 2) == 0) begin
        first  = (model_last == 1) ? 2 : 1;
        second = 3 - first;
        rs2 = 1'($urandom_range(0, 1));
        rand_ops(rs2, rc, rd);
        push_exp(first, rs, ra, rb);
        push_exp(second, rs2, rc, rd);
        set_req(first, rs, ra, rb);
        set_req(second, rs2, rc, rd);
        wait_done(first, 50);
        @(posedge clk); #1;
        drop(first);
        wait_done(second, 50);
        @(posedge clk); #1;
        drop(second);
        model_last = second;
      end else begin
        first = $urandom_range(1, 2);
        run_one(first, rs, ra, rb);
        model_last = first;
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
DIV_SHARE_CTRL -- requirements
Module: div_share_ctrl

Interface
REQ-001 Parameter: RR_EN, default 1; 1 = round-robin between lines, 0 = line1 always wins.
REQ-002 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-003 clk  in  1  clock.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 excep_flush_i  in  1  pipeline exception flush.
REQ-006 lineN_div_req_i  in  1  request from EX line N (N=1,2); held until done or cancel.
REQ-007 lineN_div_sign_i  in  1  signed divide.
REQ-008 lineN_dividend_i / lineN_divisor_i  in  32 each  operands.
REQ-009 lineN_div_done_o  out  1  one-cycle result-valid pulse to line N.
REQ-010 quotient_o / remainder_o  out  32 each  registered result.
REQ-011 busy_o  out  1  state != IDLE.
REQ-012 div_en_o, div_signed_o  out  1 each; dividend_o, divisor_o  out  32 each: drive the shared divider.
REQ-013 div_clr_o  out  1  divider synchronous clear (flush or cancel).
REQ-014 div_finished_i  in  1; div_quotient_i, div_remainder_i  in  32 each: divider outputs.

Function
REQ-015 States: IDLE, RUN, DONE.
- IDLE -> RUN when either request is high: latch owner, sign and operands.
- RUN -> DONE when div_finished_i=1: latch div_quotient_i/div_remainder_i.
- DONE -> IDLE unconditionally.
REQ-016 Grant when both lines request in IDLE:
- RR_EN=1: grant the line not equal to last_owner.
- RR_EN=0: grant line1.
- last_owner updates on every grant.
REQ-017 Single requester: grant it regardless of last_owner.
REQ-018 In RUN, div_en_o=1 and the divider operands come from the latched registers only; in IDLE and DONE, div_en_o=0.
REQ-019 In DONE, the owner's lineN_div_done_o=1 for exactly one cycle; the other line's done stays 0; quotient_o/remainder_o hold until the next DONE.
REQ-020 Latency: request sampled at cycle 0 -> RUN at cycle 1; done pulse the cycle after div_finished_i is sampled high.
REQ-021 Cancel: if the owner's request drops in RUN, div_clr_o=1 combinationally that cycle, next state is IDLE, and no done pulse is issued.
REQ-022 Flush: excep_flush_i=1 in any state forces div_clr_o=1 combinationally and next state IDLE, with no done pulse.
REQ-023 Flush overrides a simultaneous div_finished_i, cancel, or new request.
REQ-024 A request arriving during RUN/DONE from the non-owner SHALL wait; it is eligible for grant in IDLE the cycle after DONE.
REQ-025 div_finished_i in IDLE or DONE SHALL be ignored.
REQ-026 Request and operands from the non-owner SHALL never reach the divider ports.

Reset
REQ-027 On rst_n=0:
- state = IDLE; last_owner = line2, so line1 wins the first tie.
- All outputs and latched operand/result registers = 0.
REQ-028 Reset mid-RUN SHALL abandon the operation with no done pulse; the parent also resets the divider from rst_n.

Structure
REQ-029 The state encoding (2-bit IDLE/RUN/DONE), owner encoding (1-bit, 0=line1), and data width 32 SHALL live in the shared define package.
REQ-030 The grant decision SHALL be one combinational sub-module, div_grant_pick (inputs: two requests, last_owner, RR_EN; output: grant owner, grant valid).
REQ-031 The divider itself is instantiated by the parent stage, not inside this block.

Verification
REQ-032 line1 req, signed, 100/7, divider finishes after 33 cycles -> line1_div_done_o pulse one cycle later; quotient_o=14, remainder_o=2; line2_div_done_o=0.
REQ-033 line2 req, signed, -7/2 -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF; only line2 done pulses.
REQ-034 Both request in the same cycle after reset, RR_EN=1 -> line1 served first, then line2 granted in the IDLE cycle after DONE; with RR_EN=0 and line1 re-requesting, line1 is served again.
REQ-035 excep_flush_i pulsed in the cycle div_finished_i=1 -> no done pulse, div_clr_o=1 that cycle, busy_o=0 next cycle, quotient_o unchanged.
REQ-036 Owner drops its request at RUN cycle 5 -> div_clr_o=1 that cycle, IDLE next cycle; a pending line2 request is then granted with its own operands, e.g. 9/3 -> quotient_o=3, remainder_o=0.
REQ-037 rst_n asserted mid-RUN -> all outputs 0 immediately; after release, the first tie grants line1.
